// File: rtl/irq_controller.sv
// Interrupt controller: synchronised edge-triggered sources, pending/enable registers and a
// single-request REQ/ack/done handshake toward the cpu. Define IRQ_TIMER_EN to add the mtime timer source.
module irq_controller #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               reg_we,
    input  logic [2:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               irq,
    output logic [4:0]         irq_id,
    input  logic               irq_ack,
    input  logic               irq_done
);

`ifdef IRQ_TIMER_EN
    localparam int NB = NUM_SRC + 1;
`else
    localparam int NB = NUM_SRC;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_reg;
    logic [NUM_SRC-1:0] prev_reg;
    logic [NUM_SRC-1:0] edge_reg;

    logic [NB-1:0] set_vec;
    logic [NB-1:0] w1c_vec;
    logic [NB-1:0] ack_clr;
    logic [NB-1:0] clr_vec;
    logic [NB-1:0] pending_reg;
    logic [NB-1:0] enable_reg;
    logic [NB-1:0] req_vec;

    state_t     state_reg, state_next;
    logic [4:0] irq_id_reg, irq_id_next;
    logic       sel_found;
    logic [4:0] sel_id;
    logic       ack_fire;

    logic unused_wdata;
    assign unused_wdata = ^reg_wdata;

    // Edge detection is registered so a raw edge reaches pending SYNC_STAGES+1 clocks after capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= '0;
            edge_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], src_irq};
            prev_reg <= sync_reg[SYNC_STAGES-1];
            edge_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

`ifdef IRQ_TIMER_EN
    logic [31:0] mtime_reg;
    logic [31:0] mtimecmp_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_reg    <= '0;
            mtimecmp_reg <= 32'hFFFF_FFFF;
        end else begin
            mtime_reg <= mtime_reg + 32'd1;
            if (reg_we && reg_addr == 3'd5) begin
                mtimecmp_reg <= reg_wdata;
            end
        end
    end

    assign set_vec = {(mtime_reg == mtimecmp_reg), edge_reg};
`else
    assign set_vec = edge_reg;
`endif

    assign w1c_vec = (reg_we && reg_addr == 3'd1) ? reg_wdata[NB-1:0] : '0;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_ack_clr
            assign ack_clr[gi] = ack_fire && (irq_id_reg == 5'(gi));
        end
    endgenerate

    assign clr_vec = w1c_vec | ack_clr;
    assign req_vec = pending_reg & enable_reg;

    // Set is applied after clear so an edge coinciding with its clear is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            enable_reg  <= '0;
        end else begin
            pending_reg <= (pending_reg & ~clr_vec) | set_vec;
            if (reg_we && reg_addr == 3'd0) begin
                enable_reg <= reg_wdata[NB-1:0];
            end
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                sel_found = 1'b1;
                sel_id    = 5'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            irq_id_reg <= '0;
        end else begin
            state_reg  <= state_next;
            irq_id_reg <= irq_id_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        irq_id_next = irq_id_reg;
        ack_fire    = 1'b0;
        irq         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (sel_found) begin
                    irq_id_next = sel_id;
                    state_next  = ST_REQ;
                end
            end
            ST_REQ: begin
                irq = 1'b1;
                if (irq_ack) begin
                    ack_fire   = 1'b1;
                    state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign irq_id = irq_id_reg;

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            3'd0: reg_rdata = 32'(enable_reg);
            3'd1: reg_rdata = 32'(pending_reg);
            3'd2: reg_rdata = {27'b0, irq_id_reg};
            3'd3: reg_rdata = {30'b0, state_reg};
`ifdef IRQ_TIMER_EN
            3'd4: reg_rdata = mtime_reg;
            3'd5: reg_rdata = mtimecmp_reg;
`endif
            default: reg_rdata = '0;
        endcase
    end

endmodule
